// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for the data-bus responder.
// Provides the FSM state and operation enums, the data returned for an
// out-of-range read, and two small helpers: byte-lane merging and the
// wait-state LFSR step.
package data_bus_responder_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int LFSR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_resp_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } bus_op_t;

  localparam logic [WORD_W-1:0] BUS_ERR_DATA = 32'h0000_0000;

  // Replace the byte lanes of old_word whose enable bit is set.
  function automatic logic [WORD_W-1:0] merge_lanes(input logic [WORD_W-1:0] old_word,
                                                    input logic [WORD_W-1:0] new_word,
                                                    input logic [BE_W-1:0]   be);
    logic [WORD_W-1:0] res;
    res = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  // One step of the 8-bit Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3).
  function automatic logic [LFSR_W-1:0] lfsr8_next(input logic [LFSR_W-1:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// CPU data-port bus between an initiator (master) and the responder (slave).
// Signals: address, read/write enables, byte enables, write data from the
// initiator; read data, read/write ready strobes and bus_error back.
interface data_bus_responder_if;
  import data_bus_responder_pkg::*;

  logic [WORD_W-1:0] data_address;
  logic              data_read_enable;
  logic [WORD_W-1:0] data_read_data;
  logic              data_read_rdy;
  logic              data_write_enable;
  logic [BE_W-1:0]   data_write_byte_enable;
  logic [WORD_W-1:0] data_write_data;
  logic              data_write_rdy;
  logic              bus_error;

  modport master (
    output data_address, data_read_enable, data_write_enable,
           data_write_byte_enable, data_write_data,
    input  data_read_data, data_read_rdy, data_write_rdy, bus_error
  );

  modport slave (
    input  data_address, data_read_enable, data_write_enable,
           data_write_byte_enable, data_write_data,
    output data_read_data, data_read_rdy, data_write_rdy, bus_error
  );

endinterface

// File: rtl/data_bus_responder_wait_lfsr.sv
// Pseudo-random source for extra wait states.
// Ports: clk, rst (sync, active-low), advance (step once this cycle),
// seed (value loaded on reset), value (current LFSR state).
module wait_lfsr
  import data_bus_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Next state: step only when an access is accepted.
  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) begin
      lfsr_d = lfsr8_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // State register, reloaded with the seed on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/data_bus_responder.sv
// Data-bus responder: word-organised RAM behind the CPU data port with
// programmable (and optionally pseudo-random) wait states.
// Ports: clk, rst (sync, active-low), bus (slave side of the data-port
// interface). Out-of-range addresses complete normally but raise bus_error,
// return BUS_ERR_DATA on reads and never modify the RAM.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int          DEPTH         = 1024,
  parameter int          READ_LATENCY  = 1,
  parameter int          WRITE_LATENCY = 1,
  parameter int          RANDOM_WAIT   = 0,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
)(
  input  logic                 clk,
  input  logic                 rst,
  data_bus_responder_if.slave  bus
);

  localparam int AW      = $clog2(DEPTH);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  // Wait count never exceeds MAX_LAT-1+3.
  localparam int CNT_W   = $clog2(MAX_LAT + 4);
  localparam logic [CNT_W-1:0] RD_BASE = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_BASE = CNT_W'(WRITE_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (READ_LATENCY < 1) begin : g_bad_read_latency
    $error("data_bus_responder: READ_LATENCY must be >= 1");
  end
  if (WRITE_LATENCY < 1) begin : g_bad_write_latency
    $error("data_bus_responder: WRITE_LATENCY must be >= 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("data_bus_responder: DEPTH must be a power of 2");
  end

  bus_resp_state_t   state_q, state_d;
  bus_op_t           op_q, op_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              oor_q, oor_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              read_rdy_q, read_rdy_d;
  logic              write_rdy_q, write_rdy_d;
  logic              bus_err_q, bus_err_d;

  logic              accept_s;
  logic [CNT_W-1:0]  extra_s;
  logic [LFSR_W-1:0] lfsr_val_s;
  logic              unused_s;

  logic [WORD_W-1:0] mem_q [DEPTH];

  wait_lfsr u_wait_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (accept_s),
    .seed    (LFSR_SEED),
    .value   (lfsr_val_s)
  );

  assign unused_s = ^{bus.data_address[1:0], lfsr_val_s[LFSR_W-1:2]};

  // Extra wait cycles drawn from the LFSR value present at acceptance.
  always_comb begin
    extra_s = {CNT_W{1'b0}};
    if (RANDOM_WAIT != 0) begin
      extra_s = CNT_W'(lfsr_val_s[1:0]);
    end else begin
      extra_s = {CNT_W{1'b0}};
    end
  end

  // FSM next state, access capture and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    idx_d    = idx_q;
    oor_d    = oor_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.data_write_enable || bus.data_read_enable) begin
          accept_s = 1'b1;
          idx_d    = bus.data_address[AW+1:2];
          oor_d    = |bus.data_address[WORD_W-1:AW+2];
          wdata_d  = bus.data_write_data;
          be_d     = bus.data_write_byte_enable;
          // Write wins when both enables are high; the held read follows.
          if (bus.data_write_enable) begin
            op_d  = OP_WRITE;
            cnt_d = WR_BASE + extra_s;
          end else begin
            op_d  = OP_READ;
            cnt_d = RD_BASE + extra_s;
          end
          if (cnt_d == {CNT_W{1'b0}}) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = IDLE;
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = IDLE;
      end
    endcase

    // Strobes are registered on entry to RESP so they are high exactly there.
    if (state_d == RESP) begin
      read_rdy_d  = (op_d == OP_READ);
      write_rdy_d = (op_d == OP_WRITE);
      bus_err_d   = oor_d;
    end else begin
      read_rdy_d  = 1'b0;
      write_rdy_d = 1'b0;
      bus_err_d   = 1'b0;
    end

    if (read_rdy_d) begin
      if (oor_d) begin
        rdata_d = BUS_ERR_DATA;
      end else begin
        rdata_d = mem_q[idx_d];
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      idx_q       <= {AW{1'b0}};
      oor_q       <= 1'b0;
      wdata_q     <= {WORD_W{1'b0}};
      be_q        <= {BE_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      rdata_q     <= {WORD_W{1'b0}};
      read_rdy_q  <= 1'b0;
      write_rdy_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      oor_q       <= oor_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      read_rdy_q  <= read_rdy_d;
      write_rdy_q <= write_rdy_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // RAM write in the RESP cycle; contents survive reset, but a reset edge
  // landing on RESP aborts the write.
  always_ff @(posedge clk) begin
    if (rst && (state_q == RESP) && (op_q == OP_WRITE) && !oor_q) begin
      mem_q[idx_q] <= merge_lanes(mem_q[idx_q], wdata_q, be_q);
    end
  end

  assign bus.data_read_data = rdata_q;
  assign bus.data_read_rdy  = read_rdy_q;
  assign bus.data_write_rdy = write_rdy_q;
  assign bus.bus_error      = bus_err_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench: two responders (fixed waits and random waits) share
// one stimulus driver; a behavioural model predicts latency, data and errors.
module tb_data_bus_responder;

  localparam int RL0 = 3;
  localparam int WL0 = 1;
  localparam int RL1 = 2;
  localparam int WL1 = 2;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_bus_responder_if if0 ();
  data_bus_responder_if if1 ();

  logic [31:0] addr_s  = 32'h0;
  logic [31:0] wdata_s = 32'h0;
  logic [3:0]  be_s    = 4'h0;
  logic        re_s    = 1'b0;
  logic        we_s    = 1'b0;
  int          sel     = 0;

  assign if0.data_address           = addr_s;
  assign if0.data_write_data        = wdata_s;
  assign if0.data_write_byte_enable = be_s;
  assign if0.data_read_enable       = re_s && (sel == 0);
  assign if0.data_write_enable      = we_s && (sel == 0);
  assign if1.data_address           = addr_s;
  assign if1.data_write_data        = wdata_s;
  assign if1.data_write_byte_enable = be_s;
  assign if1.data_read_enable       = re_s && (sel == 1);
  assign if1.data_write_enable      = we_s && (sel == 1);

  logic        rrdy_s, wrdy_s, berr_s;
  logic [31:0] rdata_s;
  assign rrdy_s  = (sel == 0) ? if0.data_read_rdy  : if1.data_read_rdy;
  assign wrdy_s  = (sel == 0) ? if0.data_write_rdy : if1.data_write_rdy;
  assign berr_s  = (sel == 0) ? if0.bus_error      : if1.bus_error;
  assign rdata_s = (sel == 0) ? if0.data_read_data : if1.data_read_data;

  data_bus_responder #(.DEPTH(1024), .READ_LATENCY(RL0), .WRITE_LATENCY(WL0),
                       .RANDOM_WAIT(0), .LFSR_SEED(SEED))
    dut0 (.clk(clk), .rst(rst), .bus(if0));

  data_bus_responder #(.DEPTH(1024), .READ_LATENCY(RL1), .WRITE_LATENCY(WL1),
                       .RANDOM_WAIT(1), .LFSR_SEED(SEED))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [31:0] mem_m [2][1024];
  logic [31:0] last_rd_m [2];
  logic [7:0]  lfsr_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (dut%0d, t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    logic fb;
    fb = ^(v & 8'hB8);
    return {v[6:0], fb};
  endfunction

  // One access on the selected DUT, started just after a rising edge with the
  // DUT idle; finishes one idle cycle after completion.
  task automatic run_access(input bit is_wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b);
    int lat_e;
    int n;
    bit done;
    bit oor_e;
    int idx;
    logic [31:0] rd_e;
    logic other;
    oor_e = (a[31:12] != 20'h0);
    idx   = int'(a[11:2]);
    lat_e = is_wr ? ((sel == 0) ? WL0 : WL1) : ((sel == 0) ? RL0 : RL1);
    if (sel == 1) begin
      lat_e += int'(lfsr_m[1:0]);
      lfsr_m = lfsr_step(lfsr_m);
    end
    if (is_wr) begin
      if (!oor_e) begin
        for (int i = 0; i < 4; i++) begin
          if (b[i]) mem_m[sel][idx][8*i +: 8] = d[8*i +: 8];
        end
      end
    end else begin
      last_rd_m[sel] = oor_e ? 32'h0 : mem_m[sel][idx];
    end
    rd_e = last_rd_m[sel];

    addr_s = a; wdata_s = d; be_s = b; we_s = is_wr; re_s = !is_wr;
    n = 0;
    done = 1'b0;
    while (!done && n < 64) begin
      @(posedge clk); #1;
      n++;
      other = is_wr ? rrdy_s : wrdy_s;
      check_eq("other_rdy", 32'(other), 32'h0);
      done = is_wr ? wrdy_s : rrdy_s;
    end
    check_eq("latency", 32'(n), 32'(lat_e));
    check_eq("bus_error", 32'(berr_s), 32'(oor_e));
    check_eq("read_data", rdata_s, rd_e);
    we_s = 1'b0; re_s = 1'b0;
    @(posedge clk); #1;
    check_eq("rdy_single", {29'h0, rrdy_s, wrdy_s, berr_s}, 32'h0);
    check_eq("read_hold", rdata_s, rd_e);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {28'h0, if0.data_read_rdy, if0.data_write_rdy, if0.bus_error, 1'b0}, 32'h0);
    check_eq(tag, if0.data_read_data, 32'h0);
    check_eq(tag, {28'h0, if1.data_read_rdy, if1.data_write_rdy, if1.bus_error, 1'b0}, 32'h0);
    check_eq(tag, if1.data_read_data, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wn, rn, both, n;
    bit is_wr;
    logic [31:0] a;
    lfsr_m = SEED;
    last_rd_m[0] = 32'h0;
    last_rd_m[1] = 32'h0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b1;
    @(posedge clk); #1;

    // Fixed-latency DUT: basic write/read, byte lanes, zero enables
    sel = 0;
    run_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    run_access(1'b0, 32'h10, 32'h0, 4'h0);
    run_access(1'b1, 32'h20, 32'h11223344, 4'hF);
    run_access(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    run_access(1'b0, 32'h23, 32'h0, 4'h0);
    check_eq("lane_merge", last_rd_m[0], 32'h11BB33DD);
    run_access(1'b1, 32'h10, 32'h01020304, 4'h0);
    run_access(1'b0, 32'h10, 32'h0, 4'h0);

    // Simultaneous enables: write completes first, then the held read
    addr_s = 32'h30; wdata_s = 32'h5; be_s = 4'hF; we_s = 1'b1; re_s = 1'b1;
    wn = 0; rn = 0; both = 0; n = 0;
    while (rn == 0 && n < 64) begin
      @(posedge clk); #1;
      n++;
      if (rrdy_s && wrdy_s) both++;
      if (wrdy_s) begin wn = n; we_s = 1'b0; end
      if (rrdy_s) rn = n;
    end
    re_s = 1'b0;
    mem_m[0][12] = 32'h5;
    last_rd_m[0] = 32'h5;
    check_eq("simul_wr_lat", 32'(wn), 32'(WL0));
    check_eq("simul_rd_lat", 32'(rn), 32'(WL0 + 1 + RL0));
    check_eq("simul_rdata", rdata_s, 32'h5);
    check_eq("simul_coincide", 32'(both), 32'h0);
    @(posedge clk); #1;

    // Out of range
    run_access(1'b1, 32'h0, 32'hCAFE0000, 4'hF);
    run_access(1'b0, 32'h0000_1000, 32'h0, 4'h0);
    run_access(1'b1, 32'h0000_1000, 32'h12345678, 4'hF);
    run_access(1'b0, 32'h0, 32'h0, 4'h0);
    run_access(1'b0, 32'h8000_0010, 32'h0, 4'h0);

    // Random-wait DUT: preload, then random traffic
    sel = 1;
    for (int i = 0; i < 8; i++) run_access(1'b1, 32'(i * 4), $urandom(), 4'hF);
    for (int k = 0; k < 100; k++) begin
      is_wr = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom() & 32'hFFFF_F000) | 32'h0000_1000;
      run_access(is_wr, a, $urandom(), 4'($urandom_range(0, 15)));
    end

    // Reset during the WAIT of a write
    run_access(1'b1, 32'h40, 32'h7, 4'hF);
    addr_s = 32'h40; wdata_s = 32'h99; be_s = 4'hF; we_s = 1'b1;
    @(posedge clk); #1;
    check_eq("pre_rst_no_rdy", {30'h0, rrdy_s, wrdy_s}, 32'h0);
    rst = 1'b0; we_s = 1'b0;
    @(posedge clk); #1;
    check_all_zero("mid_reset");
    rst = 1'b1;
    lfsr_m = SEED;
    last_rd_m[0] = 32'h0;
    last_rd_m[1] = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("no_rdy_after_rst", {30'h0, rrdy_s, wrdy_s}, 32'h0);
    end
    run_access(1'b0, 32'h40, 32'h0, 4'h0);
    check_eq("abort_kept_old", last_rd_m[1], 32'h7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
